// File: rtl/posit_accum_sched_prodsum_es3.sv
// Interleaved accumulator around a shared 4-stage posit adder: four partial sums, then a 2-level reduction.
// Optional element counter port stat_count is built when POSIT_ACCUM_STATS_EN is defined.
`ifndef POSIT_SERIALIZED_WIDTH_SUM_PRODUCT_SUM_ES3
`define POSIT_SERIALIZED_WIDTH_SUM_PRODUCT_SUM_ES3 32
`endif

module posit_accum_sched_prodsum_es3 #(
    parameter int W = `POSIT_SERIALIZED_WIDTH_SUM_PRODUCT_SUM_ES3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_truncated,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_truncated,
    output logic         add_start,
    output logic [W-1:0] add_in1,
    output logic [W-1:0] add_in2,
    output logic         add_in1_truncated,
    output logic         add_in2_truncated,
    input  logic         add_done,
    input  logic [W-1:0] add_result,
    input  logic         add_truncated
`ifdef POSIT_ACCUM_STATS_EN
    ,
    output logic [15:0]  stat_count
`endif
);

    typedef enum logic [2:0] {S_FLUSH, S_ACCUM, S_DRAIN, S_RED1, S_RED2, S_OUT} state_t;

    localparam logic [W-1:0] ZERO = {{(W-1){1'b0}}, 1'b1};

    state_t       state_q;
    logic [2:0]   cnt_q;
    logic [1:0]   slot_q;
    logic         ret_q;
    logic         sticky_q;
    logic [W-1:0] part_q [4];
    logic [W-1:0] out_data_q;
    logic         out_trunc_q;
    logic         xfer;
    logic         enter_accum;

    assign in_ready          = (state_q == S_ACCUM);
    assign out_valid         = (state_q == S_OUT);
    assign out_data          = out_data_q;
    assign out_truncated     = out_trunc_q;
    assign add_in1_truncated = 1'b0;
    assign add_in2_truncated = 1'b0;
    assign xfer              = in_valid && (state_q == S_ACCUM);
    assign enter_accum       = ((state_q == S_FLUSH) && (cnt_q == 3'd3)) ||
                               ((state_q == S_OUT) && out_ready);

    // In ACCUM a returning result is forwarded straight into the next issue for its slot.
    always_comb begin
        add_start = 1'b0;
        add_in1   = ZERO;
        add_in2   = ZERO;
        case (state_q)
            S_ACCUM: begin
                if (in_valid) begin
                    add_start = 1'b1;
                    add_in1   = in_data;
                    add_in2   = add_done ? add_result : part_q[slot_q];
                end
            end
            S_RED1: begin
                if (cnt_q == 3'd0) begin
                    add_start = 1'b1;
                    add_in1   = part_q[0];
                    add_in2   = part_q[1];
                end else if (cnt_q == 3'd1) begin
                    add_start = 1'b1;
                    add_in1   = part_q[2];
                    add_in2   = part_q[3];
                end
            end
            S_RED2: begin
                if (cnt_q == 3'd0) begin
                    add_start = 1'b1;
                    add_in1   = part_q[0];
                    add_in2   = part_q[1];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FLUSH;
            cnt_q       <= 3'd0;
            slot_q      <= 2'd0;
            ret_q       <= 1'b0;
            sticky_q    <= 1'b0;
            out_data_q  <= ZERO;
            out_trunc_q <= 1'b0;
            for (int i = 0; i < 4; i++) part_q[i] <= ZERO;
        end else begin
            case (state_q)
                S_FLUSH: begin
                    cnt_q <= cnt_q + 3'd1;
                end
                S_ACCUM: begin
                    slot_q   <= slot_q + 2'd1;
                    sticky_q <= sticky_q | (add_done & add_truncated) | (in_valid & in_truncated);
                    if (add_done && !in_valid) part_q[slot_q] <= add_result;
                    if (in_valid && in_last) begin
                        state_q <= S_DRAIN;
                        cnt_q   <= 3'd0;
                    end
                end
                S_DRAIN: begin
                    slot_q   <= slot_q + 2'd1;
                    cnt_q    <= cnt_q + 3'd1;
                    sticky_q <= sticky_q | (add_done & add_truncated);
                    if (add_done) part_q[slot_q] <= add_result;
                    if (cnt_q == 3'd3) begin
                        state_q <= S_RED1;
                        cnt_q   <= 3'd0;
                        ret_q   <= 1'b0;
                    end
                end
                S_RED1: begin
                    cnt_q    <= cnt_q + 3'd1;
                    sticky_q <= sticky_q | (add_done & add_truncated);
                    if (add_done) begin
                        part_q[{1'b0, ret_q}] <= add_result;
                        ret_q <= 1'b1;
                        if (ret_q) begin
                            state_q <= S_RED2;
                            cnt_q   <= 3'd0;
                        end
                    end
                end
                S_RED2: begin
                    if (cnt_q == 3'd0) cnt_q <= 3'd1;
                    if (add_done) begin
                        out_data_q  <= add_result;
                        out_trunc_q <= sticky_q | add_truncated;
                        state_q     <= S_OUT;
                    end
                end
                default: ;
            endcase
            if (enter_accum) begin
                state_q  <= S_ACCUM;
                cnt_q    <= 3'd0;
                slot_q   <= 2'd0;
                sticky_q <= 1'b0;
                for (int i = 0; i < 4; i++) part_q[i] <= ZERO;
            end
        end
    end

`ifdef POSIT_ACCUM_STATS_EN
    logic [15:0] stat_q;

    always_ff @(posedge clk) begin
        if (reset || enter_accum) begin
            stat_q <= 16'd0;
        end else if (xfer && (stat_q != 16'hFFFF)) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_count = stat_q;
`endif

endmodule

// File: tb/tb_posit_accum_sched_prodsum_es3.sv
// Bench: real-valued adder model with 4-cycle latency, scoreboard of expected vector sums, timing checks.
module tb_posit_accum_sched_prodsum_es3;
  localparam int W = 32;
  localparam logic [W-1:0] ZERO = 32'h0000_0001;
  localparam logic [W-1:0] ONE = 32'h0000_0000;
  localparam logic [W-1:0] TWO = 32'h0080_0000;
  localparam logic [W-1:0] THREE = 32'h00C0_0000;
  localparam logic [W-1:0] NTHREE = 32'h80C0_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] in_data = ZERO;
  logic in_truncated = 1'b0;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic out_truncated;
  logic add_start;
  logic [W-1:0] add_in1;
  logic [W-1:0] add_in2;
  logic add_in1_truncated;
  logic add_in2_truncated;
  logic add_done;
  logic [W-1:0] add_result;
  logic add_truncated;
`ifdef POSIT_ACCUM_STATS_EN
  logic [15:0] stat_count;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;

  posit_accum_sched_prodsum_es3 #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_truncated(in_truncated), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_truncated(out_truncated),
    .add_start(add_start), .add_in1(add_in1), .add_in2(add_in2),
    .add_in1_truncated(add_in1_truncated), .add_in2_truncated(add_in2_truncated),
    .add_done(add_done), .add_result(add_result), .add_truncated(add_truncated)
`ifdef POSIT_ACCUM_STATS_EN
    , .stat_count(stat_count)
`endif
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // layout: sgn[31] scale[30:23] signed, fraction[22:2] (hidden 1), inf[1], zero[0]
  function automatic real dec(input logic [W-1:0] p);
    real v;
    int e;
    if (p[0] === 1'b1) return 0.0;
    v = 1.0 + real'(p[22:2]) / 2097152.0;
    e = int'($signed(p[30:23]));
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return (p[31] === 1'b1) ? -v : v;
  endfunction

  function automatic logic [W-1:0] enc(input real v);
    real a;
    int e;
    logic [20:0] f;
    logic [7:0] s8;
    logic sg;
    if (v == 0.0) return ZERO;
    sg = (v < 0.0);
    a = sg ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    f = 21'($rtoi((a - 1.0) * 2097152.0));
    s8 = 8'(e);
    return {sg, s8, f, 2'b00};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // behavioural adder: result valid exactly 4 cycles after add_start
  bit pv[4];
  bit [W-1:0] pr[4];
  bit pt[4];
  bit trunc_en = 1'b0;
  int trunc_events = 0;

  always @(posedge clk) begin
    bit t;
    t = trunc_en && ($urandom_range(0, 7) == 0);
    pv[0] <= add_start;
    pr[0] <= enc(dec(add_in1) + dec(add_in2));
    pt[0] <= add_start && t;
    for (int i = 1; i < 4; i++) begin
      pv[i] <= pv[i-1];
      pr[i] <= pr[i-1];
      pt[i] <= pt[i-1];
    end
    if (add_start && t) trunc_events <= trunc_events + 1;
  end

  assign add_done = pv[3];
  assign add_result = pr[3];
  assign add_truncated = pt[3];

  // scoreboard
  logic [W-1:0] exp_q[$];
  bit exp_t_q[$];
  real acc_sum = 0.0;
  bit acc_trunc = 1'b0;
  int last_a = -1000;
  int snap = 0;
  logic [W-1:0] held = ZERO;
  logic [W-1:0] last_out = ZERO;
  bit last_trunc = 1'b0;
  bit prev_ov = 1'b0;
  bit chk_rdy = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    bit et;
    if (reset) begin
      exp_q.delete();
      exp_t_q.delete();
      acc_sum = 0.0;
      acc_trunc = 1'b0;
      snap = trunc_events;
      prev_ov = 1'b0;
      chk_rdy = 1'b0;
    end else begin
      if (chk_rdy) begin
        check("in_ready_after_out", in_ready, 1);
        chk_rdy = 1'b0;
      end
      if (in_valid && in_ready) begin
        acc_sum = acc_sum + dec(in_data);
        acc_trunc = acc_trunc | in_truncated;
        if (in_last) begin
          exp_q.push_back(enc(acc_sum));
          exp_t_q.push_back(acc_trunc);
          acc_sum = 0.0;
          acc_trunc = 1'b0;
          last_a = cyc;
        end
      end
      if (out_valid && !prev_ov) begin
        check("out_valid_latency", cyc - last_a, 16);
        held = out_data;
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_data", out_data, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("result_without_vector", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          et = exp_t_q.pop_front() | (trunc_events != snap);
          check("out_data", out_data, e);
          check("out_truncated", out_truncated, et);
          check("add_trunc_ports", {add_in1_truncated, add_in2_truncated}, 0);
        end
        last_out = out_data;
        last_trunc = out_truncated;
        snap = trunc_events;
        chk_rdy = 1'b1;
      end
      prev_ov = out_valid;
    end
  end

  // driver tasks: all are entered and left at posedge+1
  task automatic send(input logic [W-1:0] d, input bit t, input bit l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_truncated = t;
    in_last = l;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_truncated = 1'b0;
    in_data = ZERO;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(posedge clk); n++; end
    #1;
    check("result_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("out_valid_timeout", out_valid, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, ZERO);
    check("rst_out_truncated", out_truncated, 0);
    check("rst_add_start", add_start, 0);
    check("rst_add_in1", add_in1, ZERO);
    check("rst_add_in2", add_in2, ZERO);
`ifdef POSIT_ACCUM_STATS_EN
    check("rst_stat_count", stat_count, 0);
`endif
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("flush_in_ready_c%0d", i), in_ready, (i == 5) ? 1 : 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int len;
    int val;
    do_reset();

    // eight +1.0 back to back
    for (int i = 0; i < 8; i++) send(ONE, 1'b0, i == 7);
    wait_result();
    check("lit_8p0", last_out, 32'h0180_0000);
    check("lit_8p0_trunc", last_trunc, 0);

    // single element
    send(TWO, 1'b0, 1'b1);
    wait_result();
    check("lit_single_2p0", last_out, 32'h0080_0000);

    // +3 and -3 separated by a gap
    send(THREE, 1'b0, 1'b0);
    idle(2);
    send(NTHREE, 1'b0, 1'b1);
    wait_result();
    check("lit_cancel_zero_flag", last_out[0], 1);

    // truncation sticky, then cleared for the next vector
    for (int i = 0; i < 5; i++) send(ONE, i == 2, i == 4);
    wait_result();
    check("lit_trunc_set", last_trunc, 1);
    check("lit_5p0", last_out, 32'h0120_0000);
    for (int i = 0; i < 5; i++) send(ONE, 1'b0, i == 4);
    wait_result();
    check("lit_trunc_clear", last_trunc, 0);

    // output back-pressure for 10 cycles
    out_ready = 1'b0;
    send(ONE, 1'b0, 1'b0);
    send(TWO, 1'b0, 1'b1);
    wait_ov();
    idle(10);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("out_valid_drop_after_accept", out_valid, 0);
    wait_result();
    check("lit_stall_3p0", last_out, 32'h00C0_0000);

    // reset while DRAIN has results in flight
    for (int i = 0; i < 3; i++) send(ONE, 1'b0, i == 2);
    idle(2);
    do_reset();
    out_ready = 1'b0;
    send(ONE, 1'b0, 1'b0);
    send(ONE, 1'b0, 1'b1);
    wait_ov();
`ifdef POSIT_ACCUM_STATS_EN
    check("stat_count_after_reset", stat_count, 2);
`endif
    out_ready = 1'b1;
    wait_result();
    check("lit_post_reset_2p0", last_out, 32'h0080_0000);

    // randomized vectors, adder truncation events enabled
    trunc_en = 1'b1;
    for (int v = 0; v < 25; v++) begin
      len = $urandom_range(1, 12);
      for (int e = 0; e < len; e++) begin
        val = int'($urandom_range(0, 16)) - 8;
        send(enc(real'(val)), $urandom_range(0, 7) == 0, e == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      wait_result();
    end
    trunc_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
